step_counter: RTL and testbench
===============================

Name: step_counter

Overview:
- Parametrised successor to the team's fixed 32-bit step-by-3 register.
- Programmable width and step, with up/down count, parallel load, synchronous clear, and wrap or saturate overflow handling.
- Reports overflow/underflow through a one-cycle pulse and a sticky flag.
- Used as the general-purpose stepped counter, for example address strides and event tallies, across HW-series designs.

Parameters:
- WIDTH, 32, counter width in bits (≥2).
- STEP_W, 8, width of the runtime step input (1..WIDTH).
- SATURATE, 0, 0 = wrap modulo 2^WIDTH on overflow/underflow; 1 = clamp at the limit.
- RESET_VALUE, 0, value loaded on reset and on sync_clr (WIDTH bits).

Ports:
- clock, in, 1, all state updates on the rising edge.
- clear_n, in, 1, asynchronous active-low reset.
- sync_clr, in, 1, synchronous clear to RESET_VALUE.
- load, in, 1, synchronous parallel load.
- load_value, in, WIDTH, data loaded when load=1.
- en, in, 1, count enable.
- up, in, 1, 1 = add step; 0 = subtract step.
- step, in, STEP_W, step size, zero-extended to WIDTH+1 bits.
- ovf_clr, in, 1, clears the sticky flag.
- value, out, WIDTH, registered count.
- wrap, out, 1, registered one-cycle pulse on overflow or underflow.
- ovf_sticky, out, 1, set by any wrap event; held until cleared.
- zero, out, 1, combinational (value == 0).

Behaviour:
- Reset: clear_n=0 asynchronously forces value=RESET_VALUE, wrap=0, ovf_sticky=0. Reset takes effect immediately, mid-count, and overrides all inputs. The first update happens on the first rising edge after clear_n deasserts.
- Per-edge priority (highest first):
  - sync_clr: value=RESET_VALUE, wrap=0, ovf_sticky=0.
  - load: value=load_value, wrap=0. ovf_sticky is unaffected apart from ovf_clr.
  - en: count as below.
  - otherwise: hold value, wrap=0.
- Count arithmetic is computed at WIDTH+1 bits:
  - up=1: sum = value + step. Overflow when sum ≥ 2^WIDTH.
  - up=0: underflow when step > value.
- No overflow/underflow: value = sum or difference, wrap=0.
- Overflow/underflow with SATURATE=0:
  - value = result mod 2^WIDTH.
  - wrap=1 for exactly one cycle.
  - ovf_sticky=1.
- Overflow/underflow with SATURATE=1:
  - value = 2^WIDTH−1 (up) or 0 (down).
  - wrap=1, ovf_sticky=1.
  - Every further saturating attempt pulses wrap again.
- step=0 with en=1: value unchanged, wrap=0.
- Latency: value and wrap reflect the inputs sampled at an edge one cycle later. zero follows value combinationally.
- ovf_clr clears ovf_sticky on the edge. If a wrap event occurs in the same cycle, set wins and ovf_sticky stays 1.
- load and en together: load wins; no count and no wrap.

Optional Feature:
- Macro: STEP_COUNTER_WRAP_COUNT_EN.
- Defined:
  - Adds output port wrap_count (8 bits), reset to 0 by clear_n and by sync_clr.
  - Increments on every cycle where wrap=1 is generated; saturates at 255.
  - Cleared by ovf_clr. If an event occurs in the same cycle as ovf_clr, wrap_count=1.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Bench uses WIDTH=8, STEP_W=4, RESET_VALUE=0.
- Reset and basic count: clear_n=0 then 1, en=1, up=1, step=3 for 4 edges -> value 0,3,6,9,12. wrap=0 throughout, zero=1 only before the first count.
- Wrap up (SATURATE=0): load 254, then en=1, up=1, step=3 -> value=1, wrap=1 for one cycle, ovf_sticky=1. The next count gives value=4 and wrap=0.
- Saturate (SATURATE=1): load 2, then up=0, step=5 -> value=0, wrap=1. Repeat -> value=0, wrap=1 again. Load 250, up=1, step=15 -> value=255.
- Priority: sync_clr, load and en all asserted with load_value=77 -> value=0 and ovf_sticky cleared. load and en with load_value=77 -> value=77, wrap=0.
- Sticky clear vs set: set ovf_sticky, then ovf_clr=1 in the same cycle as a new overflow -> ovf_sticky stays 1. ovf_clr alone on the next edge -> 0.
- Async reset mid-count: assert clear_n=0 between edges at value=9 -> value=0 immediately, without waiting for a clock edge. With STEP_COUNTER_WRAP_COUNT_EN defined, 3 wraps -> wrap_count=3, and reset -> 0.

Source files
------------

// File: rtl/step_counter.sv
// Parametrised stepped counter: up/down by a runtime step, parallel load, sync clear, wrap or saturate.
// Define STEP_COUNTER_WRAP_COUNT_EN to add the 8-bit saturating wrap_count output.
module step_counter #(
  parameter int               WIDTH       = 32,
  parameter int               STEP_W      = 8,
  parameter int               SATURATE    = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic              sync_clr,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_value,
  input  logic              en,
  input  logic              up,
  input  logic [STEP_W-1:0] step,
  input  logic              ovf_clr,
  output logic [WIDTH-1:0]  value,
  output logic              wrap,
  output logic              ovf_sticky,
  output logic              zero
`ifdef STEP_COUNTER_WRAP_COUNT_EN
  ,
  output logic [7:0]        wrap_count
`endif
);

  logic [WIDTH-1:0] value_q, value_d;
  logic             wrap_q, wrap_d;
  logic             sticky_q, sticky_d;
  logic [WIDTH:0]   stepExt;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             overflow;
  logic             underflow;
  logic             wrapEvent;

  // The extra top bit of the WIDTH+1 result is the carry (up) or borrow (down).
  assign stepExt   = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
  assign sum       = {1'b0, value_q} + stepExt;
  assign diff      = {1'b0, value_q} - stepExt;
  assign overflow  = sum[WIDTH];
  assign underflow = diff[WIDTH];
  assign wrapEvent = !sync_clr && !load && en && (up ? overflow : underflow);

  always_comb begin
    value_d  = value_q;
    wrap_d   = 1'b0;
    sticky_d = ovf_clr ? 1'b0 : sticky_q;
    if (sync_clr) begin
      value_d  = RESET_VALUE;
      sticky_d = 1'b0;
    end else if (load) begin
      value_d = load_value;
    end else if (en) begin
      if (up) begin
        value_d = (overflow && SATURATE != 0) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
      end else begin
        value_d = (underflow && SATURATE != 0) ? {WIDTH{1'b0}} : diff[WIDTH-1:0];
      end
      if (wrapEvent) begin
        wrap_d   = 1'b1;
        sticky_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      value_q  <= RESET_VALUE;
      wrap_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      value_q  <= value_d;
      wrap_q   <= wrap_d;
      sticky_q <= sticky_d;
    end
  end

  assign value      = value_q;
  assign wrap       = wrap_q;
  assign ovf_sticky = sticky_q;
  assign zero       = (value_q == '0);

`ifdef STEP_COUNTER_WRAP_COUNT_EN
  logic [7:0] wrapCount_q, wrapCount_d;

  // A same-cycle event beats ovf_clr, so the count restarts at one instead of zero.
  always_comb begin
    wrapCount_d = wrapCount_q;
    if (sync_clr) begin
      wrapCount_d = 8'd0;
    end else if (ovf_clr) begin
      wrapCount_d = wrapEvent ? 8'd1 : 8'd0;
    end else if (wrapEvent && wrapCount_q != 8'hFF) begin
      wrapCount_d = wrapCount_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      wrapCount_q <= 8'd0;
    end else begin
      wrapCount_q <= wrapCount_d;
    end
  end

  assign wrap_count = wrapCount_q;
`endif

endmodule

// File: tb/tb_step_counter.sv
// Directed-vector bench for step_counter: one wrapping and one saturating instance (WIDTH=8, STEP_W=4).
// Define STEP_COUNTER_WRAP_COUNT_EN to also check wrap_count.
module tb_step_counter;

  localparam int WIDTH  = 8;
  localparam int STEP_W = 4;

  typedef struct {
    bit         sat;
    bit         sclr;
    bit         ld;
    logic [7:0] ldv;
    bit         en;
    bit         up;
    logic [3:0] stp;
    bit         oclr;
    int         expValue;
    int         expWrap;
    int         expSticky;
    int         expZero;
    int         expWc;
  } vec_t;

  logic clock;
  logic clear_n;

  logic             wSclr, wLoad, wEn, wUp, wOclr;
  logic [WIDTH-1:0] wLoadValue;
  logic [STEP_W-1:0] wStep;
  logic [WIDTH-1:0] wValue;
  logic             wWrap, wSticky, wZero;

  logic             sSclr, sLoad, sEn, sUp, sOclr;
  logic [WIDTH-1:0] sLoadValue;
  logic [STEP_W-1:0] sStep;
  logic [WIDTH-1:0] sValue;
  logic             sWrap, sSticky, sZero;

`ifdef STEP_COUNTER_WRAP_COUNT_EN
  logic [7:0] wWc, sWc;
`endif

  int total = 0;
  int bad   = 0;
  vec_t vecs[$];

  step_counter #(.WIDTH(WIDTH), .STEP_W(STEP_W), .SATURATE(0), .RESET_VALUE(8'd0)) dutWrap (
    .clock(clock), .clear_n(clear_n), .sync_clr(wSclr), .load(wLoad), .load_value(wLoadValue),
    .en(wEn), .up(wUp), .step(wStep), .ovf_clr(wOclr),
    .value(wValue), .wrap(wWrap), .ovf_sticky(wSticky), .zero(wZero)
`ifdef STEP_COUNTER_WRAP_COUNT_EN
    , .wrap_count(wWc)
`endif
  );

  step_counter #(.WIDTH(WIDTH), .STEP_W(STEP_W), .SATURATE(1), .RESET_VALUE(8'd0)) dutSat (
    .clock(clock), .clear_n(clear_n), .sync_clr(sSclr), .load(sLoad), .load_value(sLoadValue),
    .en(sEn), .up(sUp), .step(sStep), .ovf_clr(sOclr),
    .value(sValue), .wrap(sWrap), .ovf_sticky(sSticky), .zero(sZero)
`ifdef STEP_COUNTER_WRAP_COUNT_EN
    , .wrap_count(sWc)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(bit sat, bit sclr, bit ld, int ldv, bit en, bit up, int stp, bit oclr,
                              int ev, int ew, int es, int ez, int ewc);
    vec_t v;
    v.sat = sat; v.sclr = sclr; v.ld = ld; v.ldv = ldv[7:0]; v.en = en; v.up = up;
    v.stp = stp[3:0]; v.oclr = oclr;
    v.expValue = ev; v.expWrap = ew; v.expSticky = es; v.expZero = ez; v.expWc = ewc;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic idleAll();
    wSclr = 0; wLoad = 0; wLoadValue = '0; wEn = 0; wUp = 0; wStep = '0; wOclr = 0;
    sSclr = 0; sLoad = 0; sLoadValue = '0; sEn = 0; sUp = 0; sStep = '0; sOclr = 0;
  endtask

  // Drive one record onto its target instance (the other idles), clock once, sample 1ns later.
  task automatic applyStimulus(input vec_t v, input int idx);
    string tag;
    idleAll();
    if (v.sat) begin
      sSclr = v.sclr; sLoad = v.ld; sLoadValue = v.ldv; sEn = v.en; sUp = v.up;
      sStep = v.stp; sOclr = v.oclr;
    end else begin
      wSclr = v.sclr; wLoad = v.ld; wLoadValue = v.ldv; wEn = v.en; wUp = v.up;
      wStep = v.stp; wOclr = v.oclr;
    end
    @(posedge clock);
    #1;
    tag = $sformatf("vec%0d_%s", idx, v.sat ? "sat" : "wrap");
    checkOutput({tag, "_value"},  v.sat ? int'(sValue)  : int'(wValue),  v.expValue);
    checkOutput({tag, "_wrap"},   v.sat ? int'(sWrap)   : int'(wWrap),   v.expWrap);
    checkOutput({tag, "_sticky"}, v.sat ? int'(sSticky) : int'(wSticky), v.expSticky);
    checkOutput({tag, "_zero"},   v.sat ? int'(sZero)   : int'(wZero),   v.expZero);
`ifdef STEP_COUNTER_WRAP_COUNT_EN
    checkOutput({tag, "_wcount"}, v.sat ? int'(sWc) : int'(wWc), v.expWc);
`endif
  endtask

  initial begin
    //                 sat sc ld ldv en up st oc  value w s z wc
    vecs.push_back(mk(0, 0, 0, 0,   1, 1, 3, 0,   3,   0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,   1, 1, 3, 0,   6,   0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,   1, 1, 3, 0,   9,   0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,   1, 1, 3, 0,   12,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 254, 0, 0, 0, 0,   254, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,   1, 1, 3, 0,   1,   1, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0,   1, 1, 3, 0,   4,   0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0,   1, 0, 5, 0,   255, 1, 1, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0, 0,   255, 0, 1, 0, 2));
    vecs.push_back(mk(0, 1, 1, 77,  1, 1, 3, 0,   0,   0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 77,  1, 1, 3, 0,   77,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,   1, 0, 0, 0,   77,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 250, 0, 0, 0, 0,   250, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,   1, 1, 15, 0,  9,   1, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 250, 0, 0, 0, 0,   250, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0,   1, 1, 10, 1,  4,   1, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0, 1,   4,   0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,   1, 0, 4, 0,   0,   0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,   1, 0, 1, 0,   255, 1, 1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0,   0, 0, 0, 0,   0,   0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 1, 2,   0, 0, 0, 0,   2,   0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0,   1, 0, 5, 0,   0,   1, 1, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0,   1, 0, 5, 0,   0,   1, 1, 1, 2));
    vecs.push_back(mk(1, 0, 1, 250, 0, 0, 0, 0,   250, 0, 1, 0, 2));
    vecs.push_back(mk(1, 0, 0, 0,   1, 1, 15, 0,  255, 1, 1, 0, 3));
    vecs.push_back(mk(1, 0, 0, 0,   1, 1, 0, 0,   255, 0, 1, 0, 3));
    vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0, 0,   255, 0, 1, 0, 3));

    idleAll();
    clear_n = 1'b0;
    #12;
    checkOutput("reset_value",  int'(wValue),  0);
    checkOutput("reset_wrap",   int'(wWrap),   0);
    checkOutput("reset_sticky", int'(wSticky), 0);
    checkOutput("reset_zero",   int'(wZero),   1);
    checkOutput("reset_sat_value", int'(sValue), 0);
    clear_n = 1'b1;

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // Bring the wrapping counter to 9, then drop clear_n between edges.
    for (int k = 0; k < 3; k++) applyStimulus(mk(0, 0, 0, 0, 1, 1, 3, 0, 3 * (k + 1), 0, 0, 0, 0), 100 + k);
    idleAll();
    #3;
    clear_n = 1'b0;
    #1;
    checkOutput("async_wrap_value",  int'(wValue),  0);
    checkOutput("async_wrap_zero",   int'(wZero),   1);
    checkOutput("async_sat_value",   int'(sValue),  0);
    checkOutput("async_sat_sticky",  int'(sSticky), 0);
`ifdef STEP_COUNTER_WRAP_COUNT_EN
    checkOutput("async_sat_wcount",  int'(sWc), 0);
`endif
    @(posedge clock);
    #1;
    checkOutput("held_in_reset_value", int'(wValue), 0);
    clear_n = 1'b1;
    applyStimulus(mk(0, 0, 0, 0, 1, 1, 5, 0, 5, 0, 0, 0, 0), 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
